// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO in front of a start/data/stop serialiser.
// Frames go out back to back while the FIFO holds data; writes into a full FIFO are dropped.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    send_data,
  input  logic          en_send,
  output logic          RsTx,
  output logic          tx_busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned TW         = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rstx_q, rstx_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            overflow_q;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            wr_en;
  logic            pop;
  logic            bit_end;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign RsTx     = rstx_q;
  assign tx_busy  = (state_q != StIdle) || !empty;

  // A full FIFO rejects writes even when the FSM pops in the same cycle.
  assign wr_en   = en_send && !full;
  assign bit_end = (timer_q == TW'(ClksPerBit - 1));

  // FIFO storage; not reset, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= send_data;
  end

  // State register, FIFO pointers/count and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rstx_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rstx_q     <= rstx_d;
      overflow_q <= en_send && full;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  // Next-state logic: bit timing, shifting and FIFO pops at frame boundaries.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the upcoming state so RsTx changes on the same edge as the state.
  always_comb begin
    rstx_d = 1'b1;
    unique case (state_d)
      StIdle:  rstx_d = 1'b1;
      StStart: rstx_d = 1'b0;
      StData:  rstx_d = shift_d[0];
      StStop:  rstx_d = 1'b1;
      default: rstx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames against a byte
// scoreboard, while scenario tasks check timing, flags and reset behaviour.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-parameter instance: CLKS_PER_BIT = 4, depth 4
  logic       reset, en_send;
  logic [7:0] send_data;
  logic       RsTx, tx_busy, full, empty, overflow;
  logic [2:0] count;

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_data),
    .en_send   (en_send),
    .RsTx      (RsTx),
    .tx_busy   (tx_busy),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  // Default-parameter instance for the long bit time
  logic       dflt_reset, dflt_en_send;
  logic [7:0] dflt_send_data;
  logic       dflt_RsTx, dflt_tx_busy, dflt_full, dflt_empty, dflt_overflow;
  logic [4:0] dflt_count;

  uart_tx_fifo dut_dflt (
    .clk       (clk),
    .reset     (dflt_reset),
    .send_data (dflt_send_data),
    .en_send   (dflt_en_send),
    .RsTx      (dflt_RsTx),
    .tx_busy   (dflt_tx_busy),
    .full      (dflt_full),
    .empty     (dflt_empty),
    .count     (dflt_count),
    .overflow  (dflt_overflow)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;

  // Line monitor: samples mid-bit (offset 2 of 4) and compares each frame to the scoreboard
  initial begin : monitor
    logic       prev;
    logic [7:0] got;
    logic [7:0] exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && RsTx === 1'b0) begin
        mon_busy = 1'b1;
        repeat (2) @(negedge clk);
        if (mon_en) begin
          checks++;
          if (RsTx !== 1'b0) begin
            errors++;
            $display("FAIL mon_start_bit: RsTx=%b required 0", RsTx);
          end
        end
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          got[i] = RsTx;
        end
        repeat (4) @(negedge clk);
        if (mon_en) begin
          checks++;
          if (RsTx !== 1'b1) begin
            errors++;
            $display("FAIL mon_stop_bit: RsTx=%b required 1", RsTx);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected_frame: got 0x%02h required no frame", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL mon_frame_data: got 0x%02h required 0x%02h", got, exp);
            end
          end
        end
        prev     = RsTx;
        mon_busy = 1'b0;
      end else begin
        prev = RsTx;
      end
    end
  end

  // Waits until every queued byte has been seen on the line and the DUT is idle
  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while ((sb.size() != 0 || tx_busy !== 1'b0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0 && tx_busy === 1'b0 && !mon_busy);
  endtask

  task automatic write_byte(input logic [7:0] b);
    send_data = b;
    en_send   = 1'b1;
    @(negedge clk);
    en_send   = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b1; dflt_reset = 1'b1;
    en_send = 1'b0; dflt_en_send = 1'b0;
    send_data = 8'h00; dflt_send_data = 8'h00;
    repeat (3) @(negedge clk);
    obs = {RsTx, tx_busy, full, empty, count, overflow};
    checks++;
    if (obs !== 8'b1001_0000) begin
      errors++;
      $display("FAIL reset_state: {RsTx,busy,full,empty,count,ovf}=%b required 10010000", obs);
    end
    checks++;
    if ({dflt_RsTx, dflt_tx_busy, dflt_empty, dflt_count} !== 8'b1010_0000) begin
      errors++;
      $display("FAIL reset_state_default: {RsTx,busy,empty,count}=%b required 10100000",
               {dflt_RsTx, dflt_tx_busy, dflt_empty, dflt_count});
    end
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [9:0]  fb;
    logic [39:0] obs, exp;
    logic        busy_last;
    bit          ok;
    fb = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 40; k++) exp[k] = fb[k/4];
    sb.push_back(8'h41);
    write_byte(8'h41);
    checks++;
    if (RsTx !== 1'b1) begin
      errors++;
      $display("FAIL single_latency_early: RsTx=%b one edge after write, required 1", RsTx);
    end
    @(negedge clk);
    busy_last = 1'b0;
    for (int k = 0; k < 40; k++) begin
      obs[k] = RsTx;
      if (k == 39) busy_last = tx_busy;
      @(negedge clk);
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL single_waveform: RsTx=%h required %h (bit k = cycle k)", obs, exp);
    end
    checks++;
    if (busy_last !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop: busy@39=%b busy@40=%b required 1 then 0",
               busy_last, tx_busy);
    end
    drain(100, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: %0d bytes pending required 0", sb.size());
    end
  endtask

  task automatic test_burst();
    int t_fall = -1;
    int n = 0;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h31 + 8'(i));
      send_data = 8'h31 + 8'(i);
      en_send   = 1'b1;
      @(negedge clk);
      if (RsTx === 1'b0 && t_fall < 0) t_fall = cyc;
    end
    en_send = 1'b0;
    while (tx_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (RsTx === 1'b0 && t_fall < 0) t_fall = cyc;
    end
    checks++;
    if (cyc - t_fall != 120) begin
      errors++;
      $display("FAIL burst_length: busy span %0d cycles required 120", cyc - t_fall);
    end
    drain(100, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL burst_drain: %0d bytes pending required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    int         ovf_cnt = 0;
    int         ovf_at  = -1;
    logic       ovf_full = 1'b0;
    logic [2:0] peak = '0;
    bit         ok;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        send_data = 8'hA1 + 8'(i);
        en_send   = 1'b1;
        if (i < 5) sb.push_back(8'hA1 + 8'(i));
      end else begin
        en_send = 1'b0;
      end
      @(negedge clk);
      if (overflow === 1'b1) begin
        ovf_cnt++;
        ovf_at   = i;
        ovf_full = full;
      end
      if (count > peak) peak = count;
    end
    checks++;
    if (ovf_cnt != 1 || ovf_at != 5) begin
      errors++;
      $display("FAIL overflow_pulse: %0d pulses at sample %0d required 1 at sample 5",
               ovf_cnt, ovf_at);
    end
    checks++;
    if (ovf_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: full=%b during overflow required 1", ovf_full);
    end
    checks++;
    if (peak !== 3'd4) begin
      errors++;
      $display("FAIL overflow_peak: count peak %0d required 4", peak);
    end
    drain(400, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: %0d bytes pending required 0", sb.size());
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    // writes land on edges 1..5; the first frame starts on edge 2 and pops again on edge 42
    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'hC1 + 8'(i));
      send_data = 8'hC1 + 8'(i);
      en_send   = 1'b1;
      @(negedge clk);
    end
    en_send = 1'b0;
    repeat (36) @(negedge clk);
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_before: count=%0d full=%b required 4 and 1", count, full);
    end
    write_byte(8'hC6);
    checks++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_after: count=%0d overflow=%b required 3 and 1", count, overflow);
    end
    drain(400, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_drain: %0d bytes pending required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows = 0;
    int busy_hi = 0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'hD1 + 8'(i));
      send_data = 8'hD1 + 8'(i);
      en_send   = 1'b1;
      @(negedge clk);
    end
    en_send = 1'b0;
    // frame began on edge 2; data bit 3 spans edges 18..21
    repeat (16) @(negedge clk);
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL midreset_queued: count=%0d required 2", count);
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    checks++;
    if ({RsTx, tx_busy, count, empty} !== 6'b10_0001) begin
      errors++;
      $display("FAIL midreset_state: {RsTx,busy,count,empty}=%b required 100001",
               {RsTx, tx_busy, count, empty});
    end
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (RsTx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busy_hi++;
    end
    checks++;
    if (lows != 0 || busy_hi != 0) begin
      errors++;
      $display("FAIL midreset_quiet: %0d low cycles, %0d busy cycles required 0 and 0",
               lows, busy_hi);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_ptr_wrap();
    bit ok;
    for (int i = 0; i < 40; i++) begin
      sb.push_back(8'(i * 37 + 5));
      write_byte(8'(i * 37 + 5));
      repeat (39) @(negedge clk);
    end
    drain(200, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL wrap_drain: %0d bytes pending required 0", sb.size());
    end
  endtask

  task automatic test_default_start_bit();
    int n = 0;
    int low = 0;
    dflt_reset     = 1'b0;
    @(negedge clk);
    dflt_send_data = 8'h01;
    dflt_en_send   = 1'b1;
    @(negedge clk);
    dflt_en_send   = 1'b0;
    while (dflt_RsTx === 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    while (dflt_RsTx === 1'b0 && low < 20000) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 10416) begin
      errors++;
      $display("FAIL default_start_bit: low for %0d cycles required 10416", low);
    end
    dflt_reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_ptr_wrap();
    test_default_start_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule
